pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage directly upstream of the single-cycle datapath; drives pc_out into instruction memory.
- Selects the next PC from sequential, branch, jump and register-indirect targets, applying the control decisions resolved in the datapath.
- Handles boot and stall, traps misaligned control-flow targets, supports halt, and keeps cycle and retired-instruction counters.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned target is detected.
CNT_W, 32, width of cycle_count and instret_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC this cycle; no retire
branch_taken  input  1  conditional branch resolved taken (Branch AND comparison result)
jump  input  1  PC-relative jump (JAL)
jalr  input  1  register-indirect jump
imm  input  32  sign-extended immediate from the instruction parser
rs1_data  input  32  register-file read port 1 value
halt_req  input  1  request to stop fetching
pc_out  output  32  current PC to instruction memory
pc_plus4  output  32  pc_out + 4, used as the link value
fetch_valid  output  1  pc_out holds a valid fetch this cycle
misaligned  output  1  one-cycle pulse on a trapped target
bad_target  output  32  last misaligned target captured
halted  output  1  block is in HALT
cycle_count  output  CNT_W  cycles since reset
instret_count  output  CNT_W  retired instructions since reset

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc_out=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0.
  - bad_target=0, halted=0, both counters=0.
- pc_plus4 is combinational, pc_out+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- FSM states:
  - BOOT: lasts one cycle, fetch_valid=0, PC held. Unconditionally goes to RUN; stall and halt_req are ignored in BOOT.
  - RUN: fetch_valid=1 and next-PC selection is active.
    - Go to TRAP on a misaligned selected target (when not stalled).
    - Go to HALT on halt_req (when not stalled).
  - TRAP: lasts one cycle, fetch_valid=0, pc_out=TRAP_VECTOR, misaligned=1. Then goes to RUN.
  - HALT: pc_out held, fetch_valid=0, halted=1. Exits only on reset.
- Next-PC priority in RUN: stall > halt_req > jalr > jump > branch_taken > sequential.
  - stall=1: PC and state held; instret does not increment.
  - halt_req=1: PC held, go to HALT; the current instruction is not retired.
  - jalr target = (rs1_data + imm) with bit0 cleared.
  - jump / branch_taken target = pc_out + imm.
  - sequential target = pc_plus4.
  - All sums are 32-bit and wrap silently.
- Misaligned check on the selected non-sequential target: target[1:0] != 2'b00 (for jalr, checked after bit0 is cleared).
  - On violation: bad_target <= target, PC <= TRAP_VECTOR, state <= TRAP.
  - The trapping instruction is not retired.
- Simultaneous jump, jalr and branch_taken resolve by the priority above; no error is flagged.
- Counters:
  - cycle_count increments every clock after reset in all states.
  - instret_count increments on each RUN cycle with stall=0, halt_req=0 and no trap.
  - Both wrap at 2^CNT_W.
- Latency: a new PC appears on pc_out one clock after the deciding inputs are sampled.

Test Plan:
- Reset, then 4 free-running clocks -> pc_out: 0 (BOOT, fetch_valid=0), 0, 4, 8, 0xC; instret_count=3 after the 4th edge.
- At pc=0x10, assert branch_taken with imm=0xFFFF_FFF8 -> pc_out=0x08 next cycle; with branch_taken and jump both asserted and imm=0x20 -> pc_out=0x30.
- At pc=0x40, assert jalr with rs1_data=0x1001, imm=0x4 -> pc_out=0x1004; with rs1_data=0x1002, imm=0 -> misaligned pulse, bad_target=0x1002, pc_out=0x100 for one cycle, then 0x104; instret unchanged across the trap.
- In RUN at pc=0x8, hold stall for 3 cycles, then assert halt_req -> pc_out stays 0x8, instret frozen, halted=1; halt persists with further halt_req/stall toggling until reset.
- Assert reset asynchronously between edges while at pc=0x1004 -> outputs return to reset values before the next edge; PC sequence restarts from BOOT.
- Force pc to 0xFFFF_FFFC via jalr (rs1_data=0xFFFF_FFFC, imm=0) -> next sequential pc_out=0x0; pc_plus4 reads 0x0 while pc_out=0xFFFF_FFFC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and next-PC selection with boot, trap, halt and counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jalr,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             halt_req,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic [31:0]      bad_target,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      bad_target_q, bad_target_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             misaligned_q, misaligned_d;
  logic             halted_q, halted_d;

  logic [31:0]      jalr_target;
  logic [31:0]      rel_target;
  logic [31:0]      target;
  logic             redirect;

  assign pc_plus4    = pc_q + 32'd4;
  assign jalr_target = (rs1_data + imm) & ~32'd1;
  assign rel_target  = pc_q + imm;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bad_target_d = bad_target_q;
    cycle_d      = cycle_q + CNT_ONE;
    instret_d    = instret_q;
    target       = pc_plus4;
    redirect     = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            if (jalr) begin
              target   = jalr_target;
              redirect = 1'b1;
            end else if (jump || branch_taken) begin
              target   = rel_target;
              redirect = 1'b1;
            end
            // Only redirected targets can be misaligned; pc_plus4 inherits alignment.
            if (redirect && (target[1:0] != 2'b00)) begin
              bad_target_d = target;
              pc_d         = TRAP_VECTOR;
              state_d      = S_TRAP;
            end else begin
              pc_d      = target;
              instret_d = instret_q + CNT_ONE;
            end
          end
        end
      end
      S_TRAP: begin
        pc_d    = pc_plus4;
        state_d = S_RUN;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase

    fetch_valid_d = (state_d == S_RUN);
    misaligned_d  = (state_d == S_TRAP);
    halted_d      = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      bad_target_q  <= 32'd0;
      cycle_q       <= '0;
      instret_q     <= '0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      bad_target_q  <= bad_target_d;
      cycle_q       <= cycle_d;
      instret_q     <= instret_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
      halted_q      <= halted_d;
    end
  end

  assign pc_out        = pc_q;
  assign bad_target    = bad_target_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign fetch_valid   = fetch_valid_q;
  assign misaligned    = misaligned_q;
  assign halted        = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed and randomized checks of pc_fetch_unit against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jalr = 1'b0, halt_req = 1'b0;
  logic [31:0] imm = 32'd0, rs1_data = 32'd0;
  logic [31:0] pc_out, pc_plus4, bad_target, cycle_count, instret_count;
  logic        fetch_valid, misaligned, halted;

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .jalr(jalr), .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .misaligned(misaligned), .bad_target(bad_target), .halted(halted),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  // Reference model: what the block should look like after each clock edge.
  logic [31:0] m_pc, m_bad, m_cycles, m_instret;
  bit          m_boot, m_trap, m_halted;

  always @(posedge clk or posedge reset) begin
    logic [31:0] tgt;
    bit          nonseq;
    if (reset) begin
      m_pc = RV; m_bad = 0; m_cycles = 0; m_instret = 0;
      m_boot = 1; m_trap = 0; m_halted = 0;
    end else begin
      m_cycles = m_cycles + 1;
      if (m_halted) begin
        // frozen until reset
      end else if (m_boot) begin
        m_boot = 0;
      end else if (m_trap) begin
        m_trap = 0;
        m_pc   = m_pc + 4;
      end else if (!stall) begin
        if (halt_req) begin
          m_halted = 1;
        end else begin
          tgt = m_pc + 4;
          nonseq = 0;
          if (jalr) begin
            tgt = (rs1_data + imm) & 32'hFFFF_FFFE; nonseq = 1;
          end else if (jump || branch_taken) begin
            tgt = m_pc + imm; nonseq = 1;
          end
          if (nonseq && (tgt % 4 != 0)) begin
            m_bad = tgt; m_pc = TV; m_trap = 1;
          end else begin
            m_pc = tgt; m_instret = m_instret + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk ("m.pc_out",      pc_out,        m_pc);
      chk ("m.pc_plus4",    pc_plus4,      m_pc + 32'd4);
      chk1("m.fetch_valid", fetch_valid,   !(m_boot || m_trap || m_halted));
      chk1("m.misaligned",  misaligned,    m_trap);
      chk1("m.halted",      halted,        m_halted);
      chk ("m.bad_target",  bad_target,    m_bad);
      chk ("m.cycle_count", cycle_count,   m_cycles);
      chk ("m.instret",     instret_count, m_instret);
    end
  end

  // Drive one cycle of inputs (called at posedge+1), return at the next posedge+1.
  task automatic step(input bit st, input bit hr, input bit br, input bit jp, input bit jr,
                      input logic [31:0] im, input logic [31:0] rs);
    stall = st; halt_req = hr; branch_taken = br; jump = jp; jalr = jr;
    imm = im; rs1_data = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    step(0, 0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset pulse starting between edges, released after one edge.
  task automatic async_reset(input bit pin);
    #2 reset = 1'b1;
    #1;
    if (pin) begin
      chk ("areset.pc",      pc_out,        RV);
      chk1("areset.fv",      fetch_valid,   1'b0);
      chk ("areset.bad",     bad_target,    32'd0);
      chk ("areset.instret", instret_count, 32'd0);
      chk ("areset.cycle",   cycle_count,   32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ir, im, rs;
    int r;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk ("rst.pc",      pc_out,        32'h0);
    chk1("rst.fv",      fetch_valid,   1'b0);
    chk1("rst.mis",     misaligned,    1'b0);
    chk1("rst.halted",  halted,        1'b0);
    chk ("rst.instret", instret_count, 32'h0);
    check_en = 1'b1;
    reset = 1'b0;

    // Boot then free-running sequential fetch
    seq(); chk("boot.pc1", pc_out, 32'h0); chk1("boot.fv1", fetch_valid, 1'b1);
    seq(); chk("boot.pc2", pc_out, 32'h4);
    seq(); chk("boot.pc3", pc_out, 32'h8);
    seq(); chk("boot.pc4", pc_out, 32'hC); chk("boot.instret", instret_count, 32'd3);
    seq(); chk("seq.pc10", pc_out, 32'h10);

    // Branch backwards, then branch+jump together
    step(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'd0); chk("br.back", pc_out, 32'h08);
    seq(); seq(); chk("seq.pc10b", pc_out, 32'h10);
    step(0, 0, 1, 1, 0, 32'h20, 32'd0); chk("br.jmp", pc_out, 32'h30);
    repeat (4) seq();
    chk("seq.pc40", pc_out, 32'h40);

    // jalr with bit0 cleared, then a misaligned jalr trap
    step(0, 0, 0, 0, 1, 32'h4, 32'h1001); chk("jalr.pc", pc_out, 32'h1004);
    ir = instret_count;
    step(0, 0, 0, 0, 1, 32'h0, 32'h1002);
    chk ("trap.pc",  pc_out,     32'h100);
    chk1("trap.mis", misaligned, 1'b1);
    chk ("trap.bad", bad_target, 32'h1002);
    chk ("trap.ir",  instret_count, ir);
    seq();
    chk ("trap.next",    pc_out,        32'h104);
    chk1("trap.mis_off", misaligned,    1'b0);
    chk ("trap.ir2",     instret_count, ir);

    // Asynchronous reset while at 0x1004
    step(0, 0, 0, 0, 1, 32'h4, 32'h1001); chk("jalr.pc2", pc_out, 32'h1004);
    async_reset(1);
    chk1("rst2.fv", fetch_valid, 1'b0);
    seq(); chk("rst2.pc", pc_out, 32'h0); chk1("rst2.fv1", fetch_valid, 1'b1);

    // Stall then halt at 0x8
    seq(); seq(); chk("st.pc8", pc_out, 32'h8);
    ir = instret_count;
    repeat (3) step(1, 0, 1, 0, 0, 32'h40, 32'd0);
    chk("st.pc", pc_out, 32'h8); chk("st.ir", instret_count, ir);
    step(0, 1, 0, 1, 0, 32'h40, 32'd0);
    chk("halt.pc", pc_out, 32'h8); chk1("halt.h", halted, 1'b1); chk1("halt.fv", fetch_valid, 1'b0);
    step(1, 0, 0, 1, 0, 32'h40, 32'd0);
    step(0, 0, 1, 0, 1, 32'h40, 32'h80);
    step(0, 1, 0, 0, 0, 32'h0, 32'd0);
    chk("halt.pc2", pc_out, 32'h8); chk1("halt.h2", halted, 1'b1); chk("halt.ir", instret_count, ir);

    // PC wrap
    async_reset(0);
    seq();
    step(0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC);
    chk("wrap.pc", pc_out, 32'hFFFF_FFFC); chk("wrap.p4", pc_plus4, 32'h0);
    seq(); chk("wrap.pc0", pc_out, 32'h0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        async_reset(0);
      end else begin
        r  = int'($urandom_range(0, 511));
        im = (32'(r) - 32'd256) << 2;
        if ($urandom_range(0, 7) == 0) im[1:0] = 2'($urandom_range(1, 3));
        rs = $urandom;
        if ($urandom_range(0, 3) != 0) rs[1] = 1'b0;
        step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, im, rs);
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
